// File: rtl/tono_pkg.sv
// Shared definitions for the tono_selector control stage.
// Holds the mode encodings seen on the `mode` output, the matching FSM
// state type, and the width of the step-period word N.
package tono_pkg;

  localparam int N_W = 12;

  localparam logic [1:0] MODE_MANUAL     = 2'd0;
  localparam logic [1:0] MODE_SWEEP_UP   = 2'd1;
  localparam logic [1:0] MODE_SWEEP_DOWN = 2'd2;

  typedef enum logic [1:0] {
    ST_MANUAL     = MODE_MANUAL,
    ST_SWEEP_UP   = MODE_SWEEP_UP,
    ST_SWEEP_DOWN = MODE_SWEEP_DOWN
  } state_e;

endpackage

// File: rtl/tono_selector_debounce.sv
// Button conditioner: 2-FF synchronizer, debounce counter and rising-edge
// press detector for one raw push-button.
//   clk     : sole clock
//   rst     : asynchronous active-high reset
//   btn_raw : raw asynchronous button level
//   level   : debounced button level
//   press   : one-cycle pulse when the debounced level rises
module debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             prev_q,  prev_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // The counter only advances while the synchronized input disagrees with
    // the accepted level; the flip happens on the DEB_CYCLES-th such cycle.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    prev_d  = level_q;
    press_d = level_q & ~prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      prev_q  <= prev_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/tono_selector.sv
// Converts three push-buttons into the 12-bit step-period word N for the
// downstream sine-stepping PWM generator: manual up/down steps or an
// automatic triangular sweep between N_MIN and N_MAX.
//   clk       : sole clock
//   rst       : asynchronous active-high reset
//   btn_up    : raw up button
//   btn_down  : raw down button
//   btn_mode  : raw mode button (MANUAL <-> sweep)
//   N         : registered step-period word
//   mode      : 0 MANUAL, 1 SWEEP_UP, 2 SWEEP_DOWN
//   n_changed : one-cycle pulse in the first cycle N holds a new value
//
// state         | meaning
// ST_MANUAL     | N moves only on up/down presses
// ST_SWEEP_UP   | N += STEP on each divider tick until it reaches N_MAX
// ST_SWEEP_DOWN | N -= STEP on each divider tick until it reaches N_MIN
module tono_selector
  import tono_pkg::*;
#(
  parameter int DEB_CYCLES = 50000,
  parameter int STEP       = 16,
  parameter int SWEEP_DIV  = 500000,
  parameter int N_MIN      = 1,
  parameter int N_MAX      = 4095,
  parameter int N_RESET    = 256
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           btn_up,
  input  logic           btn_down,
  input  logic           btn_mode,
  output logic [N_W-1:0] N,
  output logic [1:0]     mode,
  output logic           n_changed
);

  localparam int W1    = N_W + 1;
  localparam int DIV_W = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;

  logic ev_up, ev_down, ev_mode;
  logic lvl_up, lvl_down, lvl_mode;
  logic unused_levels;

  debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk(clk), .rst(rst), .btn_raw(btn_up), .level(lvl_up), .press(ev_up)
  );
  debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clk(clk), .rst(rst), .btn_raw(btn_down), .level(lvl_down), .press(ev_down)
  );
  debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk(clk), .rst(rst), .btn_raw(btn_mode), .level(lvl_mode), .press(ev_mode)
  );

  // Only press events drive this block; the held levels are not needed.
  assign unused_levels = lvl_up ^ lvl_down ^ lvl_mode;

  state_e           state_q, state_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             chg_q, chg_d;

  logic [W1-1:0]  sum_w, diff_w;
  logic [N_W-1:0] n_inc, n_dec;
  logic           tick;

  always_comb begin
    // 13-bit arithmetic so neither end wraps before the clamp is applied.
    sum_w  = {1'b0, n_q} + W1'(STEP);
    diff_w = {1'b0, n_q} - W1'(STEP);
    n_inc  = (sum_w > W1'(N_MAX)) ? N_W'(N_MAX) : sum_w[N_W-1:0];
    n_dec  = (diff_w[N_W] || (diff_w < W1'(N_MIN))) ? N_W'(N_MIN) : diff_w[N_W-1:0];
    tick   = (div_q == DIV_W'(SWEEP_DIV - 1));

    state_d = state_q;
    n_d     = n_q;
    div_d   = div_q;

    case (state_q)
      ST_MANUAL: begin
        div_d = '0;
        if (ev_mode) begin
          state_d = ST_SWEEP_UP;
        end else if (ev_up && !ev_down) begin
          n_d = n_inc;
        end else if (ev_down && !ev_up) begin
          n_d = n_dec;
        end
      end
      ST_SWEEP_UP: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (ev_mode) begin
          state_d = ST_MANUAL;
        end else if (tick) begin
          n_d = n_inc;
          if (n_inc == N_W'(N_MAX)) state_d = ST_SWEEP_DOWN;
        end
      end
      ST_SWEEP_DOWN: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (ev_mode) begin
          state_d = ST_MANUAL;
        end else if (tick) begin
          n_d = n_dec;
          if (n_dec == N_W'(N_MIN)) state_d = ST_SWEEP_UP;
        end
      end
      default: begin
        state_d = ST_MANUAL;
        div_d   = '0;
      end
    endcase

    chg_d = (n_d != n_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_MANUAL;
      n_q     <= N_W'(N_RESET);
      div_q   <= '0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      div_q   <= div_d;
      chg_q   <= chg_d;
    end
  end

  assign N         = n_q;
  assign mode      = state_q;
  assign n_changed = chg_q;

endmodule

// File: doc/tono_selector.md
# tono_selector

Control stage directly upstream of the sine-stepping PWM generator. It converts three raw push-buttons into the 12-bit step-period word `N` that the PWM stage compares against its internal period counter. The block supports manual up/down adjustment and an automatic triangular sweep between `N_MIN` and `N_MAX`. `N` is registered and held stable between updates, so the PWM stage can sample it on any cycle.

## Interface

**Parameters**
- `DEB_CYCLES`, 50000: consecutive stable synchronized samples required to accept a button level change.
- `STEP`, 16: amount added to or subtracted from `N` per manual press or sweep tick.
- `SWEEP_DIV`, 500000: clock cycles between sweep ticks.
- `N_MIN`, 1: lower clamp. Must be ≥ 1, because `N`=0 stalls the PWM stage.
- `N_MAX`, 4095: upper clamp. Must be ≤ 4095.
- `N_RESET`, 256: value of `N` after reset. Must satisfy `N_MIN` ≤ `N_RESET` ≤ `N_MAX`.

**Ports**
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `btn_up`, input, 1: raw button, asynchronous, active-high.
- `btn_down`, input, 1: raw button, asynchronous, active-high.
- `btn_mode`, input, 1: raw button, asynchronous, active-high.
- `N`, output, 12: step-period word to the PWM stage.
- `mode`, output, 2: current state (0 = MANUAL, 1 = SWEEP_UP, 2 = SWEEP_DOWN).
- `n_changed`, output, 1: one-cycle pulse in the first cycle `N` holds a new value.

## Operation

**Button conditioning.** Each button passes through the following chain:
- 2-FF synchronizer.
- Debounce counter: the debounced level flips only after the synchronized input differs from it for `DEB_CYCLES` consecutive cycles. Any mismatch-free cycle resets the counter to 0.
- Rising-edge detector, producing a one-cycle press event: `ev_up`, `ev_down`, `ev_mode`.
- Releases produce no event.

**State machine.**
- MANUAL:
  - `ev_mode` → SWEEP_UP.
  - Otherwise `ev_up` alone sets `N` = min(`N`+`STEP`, `N_MAX`).
  - Otherwise `ev_down` alone sets `N` = max(`N`−`STEP`, `N_MIN`).
  - `ev_up` and `ev_down` in the same cycle: ignored, `N` unchanged.
- SWEEP_UP:
  - The sweep divider counts 0 to `SWEEP_DIV`−1. On the wrap cycle (tick), `N` = min(`N`+`STEP`, `N_MAX`).
  - If the tick result equals `N_MAX`, the next state is SWEEP_DOWN.
- SWEEP_DOWN:
  - On a tick, `N` = max(`N`−`STEP`, `N_MIN`).
  - If the result equals `N_MIN`, the next state is SWEEP_UP.
- Either sweep state:
  - `ev_mode` → MANUAL, `N` held. Mode wins over a coincident tick.
  - `ev_up` and `ev_down` are ignored.
- The sweep divider clears to 0 on every entry into SWEEP_UP from MANUAL. It keeps running across UP/DOWN reversals.

**Priority, highest first:** `rst`, `ev_mode`, sweep tick, manual up/down.

**Arithmetic.**
- Sums and differences are computed 13 bits wide (zero-extended), then clamped, so there is no wrap-around at 0 or 4095.
- `N` already at a clamp and pushed further: value unchanged, no `n_changed` pulse.
- `n_changed` pulses only when the registered `N` actually differs from its previous value.

## Timing

- **Reset values** (immediately on `rst` assertion, no clock needed):
  - `N` = `N_RESET`, `mode` = 0, `n_changed` = 0.
  - Synchronizers, debounced levels, edge detectors, debounce counters and sweep divider all 0.
- **Press latency.** A raw level rising before clock edge k and held produces the event in the cycle after edge k+`DEB_CYCLES`+2. `N` and `n_changed` update on the following edge, k+`DEB_CYCLES`+3.
- **Sweep cadence.** Ticks occur every `SWEEP_DIV` cycles. The first tick is `SWEEP_DIV` cycles after the SWEEP_UP entry edge.
- **Glitch rejection.** A raw pulse shorter than `DEB_CYCLES` synchronized cycles produces no event.
- **Reset mid-sweep or mid-debounce.** All progress is discarded. Buttons held through reset deassertion generate one press event after the full debounce latency.

## Structure

- Package `tono_pkg` holds:
  - Mode encodings `MODE_MANUAL`=2'd0, `MODE_SWEEP_UP`=2'd1, `MODE_SWEEP_DOWN`=2'd2.
  - Width constant `N_W`=12.
- Sub-module `debounce`, parameterized by `DEB_CYCLES`, contains the synchronizer, counter and edge detector. It has ports `clk`, `rst`, `btn_raw`, `level`, `press`, and is instantiated three times.
- The top level contains the FSM, sweep divider, clamp arithmetic and `n_changed` generation.

## Test plan

All scenarios use `DEB_CYCLES`=4, `SWEEP_DIV`=8, `STEP`=16, `N_MIN`=1, `N_MAX`=4095 unless stated.

1. Assert `rst` for 3 cycles → `N`=256, `mode`=0, `n_changed`=0 during and after. Assert `rst` with no clock running → outputs at reset values immediately.
2. `btn_up` high for 12 cycles → `N`=272 exactly 7 edges after the first sampling edge, `n_changed` high for 1 cycle, no further change on release. Then a 3-cycle `btn_up` glitch → `N` stays 272.
3. `N_RESET`=4090, two separate `btn_up` presses → first gives `N`=4095 with a pulse; second leaves `N`=4095 with no `n_changed`. Then `btn_up` and `btn_down` pressed in the same cycle → no change.
4. `N_RESET`=10, `btn_down` press → `N`=1. Second press → `N`=1, no pulse.
5. `btn_mode` press → `mode`=1, `N` +16 every 8 cycles. `N_RESET`=4080: first tick gives 4095 and `mode`=2, next tick gives 4079. `btn_mode` press → `mode`=0, `N` frozen for 40 cycles.
6. Assert `rst` asynchronously mid-sweep, between clock edges → `N`=256, `mode`=0 before the next edge. After release, no event unless a button is held for the full debounce time.
